// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Define MULT_SIGNED_EN to honour signed_mode (two's complement); otherwise every operation is unsigned.
module seq_multiplier #(
  parameter int unsigned BITS           = 16,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [BITS-1:0]   data_a,
  input  logic [BITS-1:0]   data_b,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] result
);

  localparam int unsigned STEPS = BITS / BITS_PER_CYCLE;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PW    = 2 * BITS;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FINISH} state_t;

  state_t          r_state, w_state_nxt;
  logic [BITS-1:0] r_a;
  logic [PW-1:0]   r_b, r_acc, w_pp;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic [BITS-1:0] w_a_in, w_b_in;
  logic            w_neg_in;
  logic            w_last;
  logic            w_busy_nxt, w_done_nxt;

`ifdef MULT_SIGNED_EN
  // Magnitudes are taken in BITS width, so the most-negative value maps to 2^(BITS-1).
  always_comb begin
    w_a_in   = data_a;
    w_b_in   = data_b;
    w_neg_in = 1'b0;
    if (signed_mode) begin
      if (data_a[BITS-1]) w_a_in = '0 - data_a;
      if (data_b[BITS-1]) w_b_in = '0 - data_b;
      w_neg_in = data_a[BITS-1] ^ data_b[BITS-1];
    end
  end
`else
  logic w_unused_signed_mode;
  assign w_unused_signed_mode = signed_mode;
  assign w_a_in   = data_a;
  assign w_b_in   = data_b;
  assign w_neg_in = 1'b0;
`endif

  assign w_last = (r_cnt == CW'(STEPS - 1));

  always_comb begin
    w_pp = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_a[i]) w_pp = w_pp + (r_b << i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_MUL;
      S_MUL:    if (w_last) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (r_state == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= w_a_in;
            r_b   <= {{BITS{1'b0}}, w_b_in};
            r_acc <= '0;
            r_cnt <= '0;
            r_neg <= w_neg_in;
          end
        end
        S_MUL: begin
          r_acc <= r_acc + w_pp;
          r_a   <= r_a >> BITS_PER_CYCLE;
          r_b   <= r_b << BITS_PER_CYCLE;
          if (!w_last) r_cnt <= r_cnt + CW'(1);
        end
        S_FINISH: result <= r_neg ? ('0 - r_acc) : r_acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: edge-accurate behavioural model plus directed and random operations.
module tb_seq_multiplier;

  localparam int unsigned W     = 16;
  localparam int unsigned BPC   = 4;
  localparam int unsigned STEPS = W / BPC;
  localparam int unsigned PW    = 2 * W;
`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [W-1:0]  data_a = '0;
  logic [W-1:0]  data_b = '0;
  logic          busy, done;
  logic [PW-1:0] result;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  seq_multiplier #(.BITS(W), .BITS_PER_CYCLE(BPC)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint x, y, p;
    bit sg;
    sg = s & SIGNED_BUILD;
    x = longint'(a);
    y = longint'(b);
    if (sg && a[W-1]) x = x - (longint'(1) << W);
    if (sg && b[W-1]) y = y - (longint'(1) << W);
    p = x * y;
    return p[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model in edge numbers: op accepted at edge e completes (done) at edge e+STEPS+1.
  longint        m_e, m_acc_e, m_fin;
  logic [PW-1:0] m_res, m_pend;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_e = 0; m_acc_e = -100; m_fin = -100; m_res = '0; m_pend = '0;
    end else begin
      m_e++;
      if (m_e > m_fin && start) begin
        m_acc_e = m_e;
        m_fin   = m_e + STEPS + 1;
        m_pend  = ref_mul(data_a, data_b, signed_mode);
      end
      if (m_e == m_fin) m_res = m_pend;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy",   PW'(busy),   PW'(m_e >= m_acc_e && m_e < m_fin));
      check("done",   PW'(done),   PW'(m_e == m_fin));
      check("result", result,      m_res);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int lat, output int bcnt);
    data_a = a; data_b = b; signed_mode = s; start = 1'b1;
    tick();
    start = 1'b0;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
    check("done_seen", PW'(done), PW'(1));
  endtask

  initial begin
    int lat, bc, ndone;
    logic [PW-1:0] exp_t2, exp_t6;
    exp_t2 = SIGNED_BUILD ? 32'hFFFF_FFEB : 32'h0006_FFEB;
    exp_t6 = SIGNED_BUILD ? 32'hFFFF_FFFE : 32'h0001_FFFE;

    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",   PW'(busy), '0);
    check("rst_done",   PW'(done), '0);
    check("rst_result", result,    '0);
    check("model_ffff", ref_mul(16'hFFFF, 16'hFFFF, 1'b0), 32'hFFFE_0001);
    check("model_neg",  ref_mul(16'hFFFD, 16'h0007, 1'b1), exp_t2);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    do_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bc);
    check("t1_latency", PW'(lat), PW'(STEPS + 2));
    check("t1_busy_len", PW'(bc), PW'(STEPS + 1));
    check("t1_result", result, 32'hFFFE_0001);

    do_op(16'hFFFD, 16'h0007, 1'b1, lat, bc);
    check("t2_result_a", result, exp_t2);
    do_op(16'h8000, 16'h8000, 1'b1, lat, bc);
    check("t2_result_b", result, 32'h4000_0000);
    tick();

    data_a = 16'd5; data_b = 16'd7; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    data_a = 16'd2; data_b = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin tick(); lat++; end
    check("t3_done_seen", PW'(done), PW'(1));
    check("t3_result", result, 32'h0000_0023);
    ndone = 0;
    repeat (2 * STEPS + 4) begin tick(); if (done) ndone++; end
    check("t3_no_extra_done", PW'(ndone), '0);
    check("t3_result_held", result, 32'h0000_0023);

    do_op(16'd5, 16'd7, 1'b0, lat, bc);
    check("t4_result_a", result, 32'h0000_0023);
    do_op(16'd2, 16'd3, 1'b0, lat, bc);
    check("t4_gap", PW'(lat), PW'(STEPS + 2));
    check("t4_result_b", result, 32'h0000_0006);

    do_op(16'hFFFF, 16'h0002, 1'b1, lat, bc);
    check("t6_result", result, exp_t6);
    tick();

    data_a = 16'd9; data_b = 16'd11; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy",   PW'(busy), '0);
    check("t5_done",   PW'(done), '0);
    check("t5_result", result,    '0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(16'd9, 16'd11, 1'b0, lat, bc);
    check("t5_after_result", result, 32'h0000_0063);
    check("t5_after_latency", PW'(lat), PW'(STEPS + 2));

    repeat (400) begin
      case ($urandom_range(0, 7))
        0: data_a = '0;
        1: data_a = 16'h8000;
        2: data_a = 16'hFFFF;
        default: data_a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: data_b = '0;
        1: data_b = 16'h8000;
        2: data_b = 16'hFFFF;
        default: data_b = W'($urandom);
      endcase
      signed_mode = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 1'b0;
    repeat (STEPS + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
